// File: rtl/cluster_unpacker.sv
// cluster_unpacker
//   Decodes the cluster stream produced by the cluster packer. Every clock4x
//   cycle carries NCLUSTERS {cnt, adr} slots. Each valid slot is expanded into
//   a run of cnt+1 strips starting at adr. All clusters of one bunch crossing
//   are ORed into an NSTRIPS-wide S-bit map, which is presented once per BX.
//   Used both as a loopback checker for the packer and on the receive side.
//
// Ports
//   clock4x        in   160 MHz clock, the only clock in the block
//   reset          in   synchronous, active-high reset
//   frame_start    in   high on the first clock4x cycle of each BX
//   clusters_in    in   slot i = [i*SLOTW +: SLOTW] = {cnt, adr}
//   vpfs_out       out  reconstructed S-bit map of the last completed BX
//   vpfs_valid     out  one-cycle pulse when vpfs_out/nclusters_out/frame_err update
//   nclusters_out  out  valid clusters accepted in that BX (saturates at 63)
//   frame_err      out  BX length differed from FRAME_CYCLES (qualified by vpfs_valid)
//   sync_ok        out  high while the frame marker has been acquired
//
// state  | meaning
// -------+------------------------------------------------------------------
// UNSYNC | no frame_start seen since reset; clusters are ignored
// SYNC   | frame marker acquired; clusters accumulate, each marker closes a BX

module cluster_unpacker #(
  parameter int NSTRIPS      = 1536,
  parameter int NCLUSTERS    = 8,
  parameter int ADRW         = 11,
  parameter int CNTW         = 3,
  parameter int FRAME_CYCLES = 4
) (
  input  logic                                clock4x,
  input  logic                                reset,
  input  logic                                frame_start,
  input  logic [NCLUSTERS*(CNTW+ADRW)-1:0]    clusters_in,
  output logic [NSTRIPS-1:0]                  vpfs_out,
  output logic                                vpfs_valid,
  output logic [5:0]                          nclusters_out,
  output logic                                frame_err,
  output logic                                sync_ok
);

  localparam int SLOTW = CNTW + ADRW;
  localparam int VCW   = $clog2(NCLUSTERS + 1);
  localparam int CYCW  = $clog2(FRAME_CYCLES + 1);
  localparam int CCW   = 6;
  localparam int RUNL  = 1 << CNTW;

  // Strip indices are evaluated one bit wider than the address so that
  // adr+cnt running past the last strip can be detected and clipped.
  localparam logic [ADRW:0]   NSTRIPS_X = (ADRW+1)'(NSTRIPS);
  localparam logic [CYCW-1:0] CYC_LAST  = CYCW'(FRAME_CYCLES - 1);
  localparam logic [CYCW-1:0] CYC_SAT   = CYCW'(FRAME_CYCLES);

  typedef enum logic {
    UNSYNC = 1'b0,
    SYNC   = 1'b1
  } state_t;

  state_t               state;
  logic [NSTRIPS-1:0]   acc;
  logic [CCW-1:0]       ccount;
  logic [CYCW-1:0]      cyc;

  logic [NSTRIPS-1:0]   exp_map;
  logic [VCW-1:0]       vcount;
  logic [CCW:0]         csum;
  logic [CCW-1:0]       ccount_sat;
  logic [CYCW-1:0]      cyc_next;

  // Expand every slot of the current cycle into its strip run.
  always_comb begin
    logic [ADRW-1:0] slot_adr;
    logic [CNTW-1:0] slot_cnt;
    logic [ADRW:0]   strip;
    exp_map  = '0;
    vcount   = '0;
    slot_adr = '0;
    slot_cnt = '0;
    strip    = '0;
    for (int i = 0; i < NCLUSTERS; i++) begin
      slot_adr = clusters_in[i*SLOTW +: ADRW];
      slot_cnt = clusters_in[i*SLOTW + ADRW +: CNTW];
      if ({1'b0, slot_adr} < NSTRIPS_X) begin
        vcount = vcount + VCW'(1);
        for (int k = 0; k < RUNL; k++) begin
          strip = {1'b0, slot_adr} + (ADRW+1)'(k);
          // Runs are clipped at the top of the map, never wrapped.
          if ((CNTW'(k) <= slot_cnt) && (strip < NSTRIPS_X)) begin
            exp_map[strip[ADRW-1:0]] = 1'b1;
          end
        end
      end
    end
  end

  // Cluster count only saturates on overlong BXs; the nominal maximum fits.
  always_comb begin
    csum       = {1'b0, ccount} + (CCW+1)'(vcount);
    ccount_sat = csum[CCW] ? '1 : csum[CCW-1:0];
    cyc_next   = (cyc == CYC_SAT) ? cyc : cyc + CYCW'(1);
  end

  always_ff @(posedge clock4x) begin
    if (reset) begin
      state         <= UNSYNC;
      acc           <= '0;
      ccount        <= '0;
      cyc           <= '0;
      vpfs_out      <= '0;
      vpfs_valid    <= 1'b0;
      nclusters_out <= '0;
      frame_err     <= 1'b0;
      sync_ok       <= 1'b0;
    end else begin
      vpfs_valid <= 1'b0;
      case (state)
        UNSYNC: begin
          // First marker only opens a BX; there is nothing to close yet.
          if (frame_start) begin
            acc     <= exp_map;
            ccount  <= CCW'(vcount);
            cyc     <= '0;
            state   <= SYNC;
            sync_ok <= 1'b1;
          end
        end
        SYNC: begin
          if (frame_start) begin
            // Clusters on the marker cycle already belong to the new BX.
            vpfs_out      <= acc;
            nclusters_out <= ccount;
            frame_err     <= (cyc != CYC_LAST);
            vpfs_valid    <= 1'b1;
            acc           <= exp_map;
            ccount        <= CCW'(vcount);
            cyc           <= '0;
          end else begin
            acc    <= acc | exp_map;
            ccount <= ccount_sat;
            cyc    <= cyc_next;
          end
        end
        default: begin
          state   <= UNSYNC;
          sync_ok <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cluster_unpacker.sv
module tb_cluster_unpacker;

  localparam int NS   = 1536;
  localparam int NC   = 8;
  localparam int SW   = 14;
  localparam int DW   = NC * SW;
  localparam int NOMINAL = 4;
  localparam logic [DW-1:0] EMPTY = {NC{14'h07FF}};

  logic            clock4x = 1'b0;
  logic            reset = 1'b1;
  logic            frame_start = 1'b0;
  logic [DW-1:0]   clusters_in = EMPTY;
  logic [NS-1:0]   vpfs_out;
  logic            vpfs_valid;
  logic [5:0]      nclusters_out;
  logic            frame_err;
  logic            sync_ok;

  cluster_unpacker dut (
    .clock4x(clock4x),
    .reset(reset),
    .frame_start(frame_start),
    .clusters_in(clusters_in),
    .vpfs_out(vpfs_out),
    .vpfs_valid(vpfs_valid),
    .nclusters_out(nclusters_out),
    .frame_err(frame_err),
    .sync_ok(sync_ok)
  );

  always #5 clock4x = ~clock4x;

  int n_tests = 0;
  int n_fail  = 0;
  bit checking = 1'b0;

  // Reference model: list of clusters of the open BX and its length in cycles.
  bit            m_synced = 1'b0;
  logic [13:0]   bx_list[$];
  int            bx_len = 0;
  bit [NS-1:0]   e_map = '0;
  int            e_cnt = 0;
  bit            e_err = 1'b0;
  bit            e_valid = 1'b0;
  bit            e_sync = 1'b0;

  task automatic chk(input string name, input bit ok, input longint act, input longint exp);
    n_tests++;
    if (!ok) begin
      n_fail++;
      $display("FAIL %s: actual %0d required %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [13:0] slot(input int cnt, input int adr);
    return {3'(cnt), 11'(adr)};
  endfunction

  task automatic model_close();
    bit [NS-1:0] m;
    int a, c;
    m = '0;
    foreach (bx_list[j]) begin
      a = int'(bx_list[j][10:0]);
      c = int'(bx_list[j][13:11]);
      for (int s = a; s <= a + c; s++)
        if (s < NS) m[s] = 1'b1;
    end
    e_map   = m;
    e_cnt   = (bx_list.size() > 63) ? 63 : bx_list.size();
    e_err   = (bx_len != NOMINAL);
    e_valid = 1'b1;
  endtask

  task automatic model_step(input bit rst, input bit fs, input logic [DW-1:0] d);
    logic [13:0] s;
    if (rst) begin
      m_synced = 1'b0;
      bx_list.delete();
      bx_len  = 0;
      e_map   = '0;
      e_cnt   = 0;
      e_err   = 1'b0;
      e_valid = 1'b0;
      e_sync  = 1'b0;
      return;
    end
    e_valid = 1'b0;
    if (fs) begin
      if (m_synced) model_close();
      bx_list.delete();
      bx_len   = 0;
      m_synced = 1'b1;
      e_sync   = 1'b1;
    end
    if (m_synced) begin
      for (int i = 0; i < NC; i++) begin
        s = d[i*SW +: SW];
        if (int'(s[10:0]) < NS) bx_list.push_back(s);
      end
      bx_len++;
    end
  endtask

  // One clock4x cycle: inputs set after the previous edge, model advanced at
  // the edge, caller resumes 1 time unit after the edge.
  task automatic cyc(input bit rst, input bit fs, input logic [DW-1:0] d);
    reset       = rst;
    frame_start = fs;
    clusters_in = d;
    @(posedge clock4x);
    model_step(rst, fs, d);
    #1;
  endtask

  // Compare process: all outputs are held registers, so check every cycle.
  always @(negedge clock4x) begin
    if (checking) begin
      chk("vpfs_valid", vpfs_valid == e_valid, vpfs_valid, e_valid);
      chk("sync_ok", sync_ok == e_sync, sync_ok, e_sync);
      chk("nclusters_out", nclusters_out == 6'(e_cnt), nclusters_out, e_cnt);
      chk("frame_err", frame_err == e_err, frame_err, e_err);
      chk("vpfs_out", vpfs_out == e_map, $countones(vpfs_out), $countones(e_map));
    end
  end

  logic [DW-1:0] d;
  logic [DW-1:0] d0;

  // Sequence used before and after the mid-frame reset.
  task automatic seq_basic();
    logic [DW-1:0] x;
    x = EMPTY;
    x[0 +: SW] = slot(2, 10);
    cyc(0, 1, x);
    for (int c = 1; c < NOMINAL; c++) cyc(0, 0, EMPTY);
    chk("basic_no_early_valid", vpfs_valid == 1'b0, vpfs_valid, 0);
    cyc(0, 1, EMPTY);
    chk("basic_valid", vpfs_valid == 1'b1, vpfs_valid, 1);
    chk("basic_bits", vpfs_out[12:10] == 3'b111, vpfs_out[12:10], 7);
    chk("basic_popcount", $countones(vpfs_out) == 3, $countones(vpfs_out), 3);
    chk("basic_count", nclusters_out == 6'd1, nclusters_out, 1);
    chk("basic_err", frame_err == 1'b0, frame_err, 0);
    for (int c = 1; c < NOMINAL; c++) cyc(0, 0, EMPTY);
    chk("basic_pulse_once", vpfs_valid == 1'b0, vpfs_valid, 0);
  endtask

  initial begin
    // 1. reset and behaviour without a frame marker
    for (int c = 0; c < 3; c++) cyc(1, 0, EMPTY);
    chk("rst_map", vpfs_out == '0, $countones(vpfs_out), 0);
    chk("rst_sync", sync_ok == 1'b0, sync_ok, 0);
    chk("rst_valid", vpfs_valid == 1'b0, vpfs_valid, 0);
    chk("rst_count", nclusters_out == 6'd0, nclusters_out, 0);
    checking = 1'b1;
    d = EMPTY;
    d[0 +: SW] = slot(1, 5);
    for (int c = 0; c < 4; c++) cyc(0, 0, d);
    chk("unsync_sync_ok", sync_ok == 1'b0, sync_ok, 0);

    // 2. nominal BX with one cluster
    seq_basic();

    // 3. top-edge clipping, then a BX of empty slots (adr 0x7FE)
    d = EMPTY;
    d[3*SW +: SW] = slot(7, 1534);
    cyc(0, 1, d);
    for (int c = 1; c < NOMINAL; c++) cyc(0, 0, EMPTY);
    d0 = {NC{14'h07FE}};
    cyc(0, 1, d0);
    chk("clip_top", vpfs_out[1535:1534] == 2'b11, vpfs_out[1535:1534], 3);
    chk("clip_nowrap", vpfs_out[0] == 1'b0, vpfs_out[0], 0);
    chk("clip_popcount", $countones(vpfs_out) == 2, $countones(vpfs_out), 2);
    for (int c = 1; c < NOMINAL; c++) cyc(0, 0, d0);

    // 4. full BX of distinct clusters, then duplicates
    for (int c = 0; c < NOMINAL; c++) begin
      for (int i = 0; i < NC; i++) d[i*SW +: SW] = slot(1, (c*NC + i) * 40);
      cyc(0, c == 0, d);
    end
    chk("empty_count", nclusters_out == 6'd0, nclusters_out, 0);
    chk("empty_map", vpfs_out == '0, $countones(vpfs_out), 0);
    d = EMPTY;
    d[1*SW +: SW] = slot(3, 100);
    d[6*SW +: SW] = slot(3, 100);
    cyc(0, 1, d);
    chk("full_count", nclusters_out == 6'd32, nclusters_out, 32);
    chk("full_popcount", $countones(vpfs_out) == 64, $countones(vpfs_out), 64);
    for (int c = 1; c < NOMINAL; c++) cyc(0, 0, EMPTY);

    // 5. short BX, long BX, overlong BX (count saturation), then nominal
    cyc(0, 1, EMPTY);
    chk("dup_count", nclusters_out == 6'd2, nclusters_out, 2);
    chk("dup_map", vpfs_out[103:100] == 4'hF && $countones(vpfs_out) == 4,
        $countones(vpfs_out), 4);
    for (int c = 1; c < 3; c++) cyc(0, 0, EMPTY);
    cyc(0, 1, EMPTY);
    chk("short_err", frame_err == 1'b1, frame_err, 1);
    for (int c = 1; c < 6; c++) cyc(0, 0, EMPTY);
    for (int i = 0; i < NC; i++) d[i*SW +: SW] = slot(0, i * 3);
    cyc(0, 1, d);
    chk("long_err", frame_err == 1'b1, frame_err, 1);
    for (int c = 1; c < 9; c++) cyc(0, 0, d);
    cyc(0, 1, EMPTY);
    chk("sat_count", nclusters_out == 6'd63, nclusters_out, 63);
    for (int c = 1; c < NOMINAL; c++) cyc(0, 0, EMPTY);
    cyc(0, 1, EMPTY);
    chk("nominal_err", frame_err == 1'b0, frame_err, 0);
    for (int c = 1; c < NOMINAL; c++) cyc(0, 0, EMPTY);

    // 6. reset on cycle 2 of a BX with clusters
    d = EMPTY;
    d[2*SW +: SW] = slot(4, 700);
    cyc(0, 1, d);
    cyc(0, 0, d);
    cyc(1, 0, d);
    chk("midrst_sync", sync_ok == 1'b0, sync_ok, 0);
    for (int c = 0; c < 3; c++) cyc(0, 0, d);
    chk("midrst_no_valid", vpfs_valid == 1'b0, vpfs_valid, 0);
    seq_basic();

    // 7. randomized BXs against the model
    for (int f = 0; f < 200; f++) begin
      int len;
      len = ($urandom_range(0, 7) == 0) ? int'($urandom_range(1, 7)) : NOMINAL;
      for (int c = 0; c < len; c++) begin
        for (int i = 0; i < NC; i++) begin
          case ($urandom_range(0, 3))
            0: d[i*SW +: SW] = slot($urandom_range(0, 7), $urandom_range(NS, 2047));
            1: d[i*SW +: SW] = slot($urandom_range(0, 7), $urandom_range(NS - 8, NS - 1));
            default: d[i*SW +: SW] = slot($urandom_range(0, 7), $urandom_range(0, NS - 1));
          endcase
        end
        cyc(0, c == 0, d);
      end
    end
    cyc(0, 1, EMPTY);
    cyc(0, 0, EMPTY);
    checking = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
